// File: rtl/mem_stage_access_unit.sv
// Memory-stage access unit: turns the EX/MEM load/store request into a
// req/ack transaction on a word-wide data bus, stalls the pipeline while the
// access is outstanding, and returns aligned, extended load data.
module mem_stage_access_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        IN_DATAMEMSEL,
    input  logic [3:0]  IN_READ_WRITE,
    input  logic [31:0] IN_ADDRESS,
    input  logic [31:0] IN_STORE_DATA,
    output logic [31:0] OUT_LOAD_DATA,
    output logic        OUT_BUSY,
    output logic        OUT_MISALIGNED,
    output logic        OUT_BUS_ERROR,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [31:0] MEM_ADDR,
    output logic [31:0] MEM_WDATA,
    output logic [3:0]  MEM_BYTE_EN,
    input  logic [31:0] MEM_RDATA,
    input  logic        MEM_ACK
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    // Last count value before expiry: the edge that would make the count
    // reach TIMEOUT_CYCLES ends the access.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_reg, state_next;
    logic        mem_req_reg, mem_req_next;
    logic        mem_we_reg, mem_we_next;
    logic [3:0]  byte_en_reg, byte_en_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] wdata_reg, wdata_next;
    logic [31:0] load_data_reg, load_data_next;
    logic [7:0]  count_reg, count_next;
    logic        err_reg, err_next;
    logic [1:0]  lane_reg, lane_next;
    logic [1:0]  size_reg, size_next;
    logic        unsigned_reg, unsigned_next;

    logic        req_aligned;
    logic [3:0]  req_byte_en;
    logic [31:0] req_wdata;
    logic [15:0] rd_half;
    logic [7:0]  rd_byte;
    logic [31:0] rd_extended;
    logic        busy_comb;
    logic        misaligned_comb;
    logic        bus_error_comb;

    // Decode alignment, byte lanes and replicated store data of the incoming request.
    always_comb begin
        req_aligned = 1'b0;
        req_byte_en = 4'b1111;
        req_wdata   = IN_STORE_DATA;
        case (IN_READ_WRITE[1:0])
            2'b00: begin
                req_aligned = 1'b1;
                req_byte_en = 4'b0001 << IN_ADDRESS[1:0];
                req_wdata   = {4{IN_STORE_DATA[7:0]}};
            end
            2'b01: begin
                req_aligned = ~IN_ADDRESS[0];
                req_byte_en = 4'b0011 << IN_ADDRESS[1:0];
                req_wdata   = {2{IN_STORE_DATA[15:0]}};
            end
            2'b10: begin
                req_aligned = (IN_ADDRESS[1:0] == 2'b00);
            end
            default: begin
                req_aligned = 1'b0;
            end
        endcase
    end

    // Select the addressed lane of the read data and sign/zero-extend it.
    always_comb begin
        rd_byte     = MEM_RDATA[8*lane_reg +: 8];
        rd_half     = lane_reg[1] ? MEM_RDATA[31:16] : MEM_RDATA[15:0];
        rd_extended = MEM_RDATA;
        case (size_reg)
            2'b00:   rd_extended = {{24{rd_byte[7] & ~unsigned_reg}}, rd_byte};
            2'b01:   rd_extended = {{16{rd_half[15] & ~unsigned_reg}}, rd_half};
            default: rd_extended = MEM_RDATA;
        endcase
    end

    // Next-state and combinational status outputs of the access FSM.
    always_comb begin
        state_next      = state_reg;
        mem_req_next    = mem_req_reg;
        mem_we_next     = mem_we_reg;
        byte_en_next    = byte_en_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        load_data_next  = load_data_reg;
        count_next      = count_reg;
        err_next        = err_reg;
        lane_next       = lane_reg;
        size_next       = size_reg;
        unsigned_next   = unsigned_reg;
        busy_comb       = 1'b0;
        misaligned_comb = 1'b0;
        bus_error_comb  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (IN_DATAMEMSEL) begin
                    if (req_aligned) begin
                        busy_comb     = 1'b1;
                        mem_req_next  = 1'b1;
                        mem_we_next   = IN_READ_WRITE[3];
                        // Byte enables and write data only mean something for stores.
                        byte_en_next  = IN_READ_WRITE[3] ? req_byte_en : 4'b0000;
                        wdata_next    = IN_READ_WRITE[3] ? req_wdata : 32'd0;
                        addr_next     = {IN_ADDRESS[31:2], 2'b00};
                        lane_next     = IN_ADDRESS[1:0];
                        size_next     = IN_READ_WRITE[1:0];
                        unsigned_next = IN_READ_WRITE[2];
                        count_next    = 8'd0;
                        err_next      = 1'b0;
                        state_next    = ACCESS;
                    end else begin
                        misaligned_comb = 1'b1;
                        if (!IN_READ_WRITE[3]) begin
                            load_data_next = 32'd0;
                        end
                    end
                end
            end
            ACCESS: begin
                busy_comb  = 1'b1;
                count_next = count_reg + 8'd1;
                // An ack in the expiry cycle wins over the timeout.
                if (MEM_ACK) begin
                    if (!mem_we_reg) begin
                        load_data_next = rd_extended;
                    end
                    mem_req_next = 1'b0;
                    mem_we_next  = 1'b0;
                    byte_en_next = 4'b0000;
                    state_next   = DONE;
                end else if (count_reg == TIMEOUT_LAST) begin
                    // A timed-out store leaves the last load result alone.
                    if (!mem_we_reg) begin
                        load_data_next = 32'd0;
                    end
                    mem_req_next = 1'b0;
                    mem_we_next  = 1'b0;
                    byte_en_next = 4'b0000;
                    err_next     = 1'b1;
                    state_next   = DONE;
                end
            end
            DONE: begin
                bus_error_comb = err_reg;
                err_next       = 1'b0;
                count_next     = 8'd0;
                state_next     = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and bus registers; reset abandons any outstanding access.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg     <= IDLE;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            byte_en_reg   <= 4'b0000;
            addr_reg      <= 32'd0;
            wdata_reg     <= 32'd0;
            load_data_reg <= 32'd0;
            count_reg     <= 8'd0;
            err_reg       <= 1'b0;
            lane_reg      <= 2'b00;
            size_reg      <= 2'b00;
            unsigned_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            mem_req_reg   <= mem_req_next;
            mem_we_reg    <= mem_we_next;
            byte_en_reg   <= byte_en_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            load_data_reg <= load_data_next;
            count_reg     <= count_next;
            err_reg       <= err_next;
            lane_reg      <= lane_next;
            size_reg      <= size_next;
            unsigned_reg  <= unsigned_next;
        end
    end

    // Status outputs are forced low while reset is held, even with a request present.
    assign OUT_BUSY       = busy_comb & ~RESET;
    assign OUT_MISALIGNED = misaligned_comb & ~RESET;
    assign OUT_BUS_ERROR  = bus_error_comb;
    assign OUT_LOAD_DATA  = load_data_reg;
    assign MEM_REQ        = mem_req_reg;
    assign MEM_WE         = mem_we_reg;
    assign MEM_BYTE_EN    = byte_en_reg;
    assign MEM_ADDR       = addr_reg;
    assign MEM_WDATA      = wdata_reg;

endmodule

// File: tb/tb_mem_stage_access_unit.sv
// Self-checking bench for mem_stage_access_unit: directed table, reset
// sequence and randomized operations against a behavioural model.
module tb_mem_stage_access_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic [3:0]  rw;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] load_data;
    logic        busy;
    logic        mis;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int total = 0;
    int bad   = 0;
    logic [31:0] model_load;

    typedef struct {
        logic        st;
        logic        uns;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] rdata;
        int          delay;
        logic [31:0] load;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        mis;
        logic        err;
    } vec_t;

    always #5 clk = ~clk;

    mem_stage_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .CLK(clk), .RESET(reset), .IN_DATAMEMSEL(sel), .IN_READ_WRITE(rw),
        .IN_ADDRESS(addr), .IN_STORE_DATA(sdata), .OUT_LOAD_DATA(load_data),
        .OUT_BUSY(busy), .OUT_MISALIGNED(mis), .OUT_BUS_ERROR(bus_err),
        .MEM_REQ(mem_req), .MEM_WE(mem_we), .MEM_ADDR(mem_addr),
        .MEM_WDATA(mem_wdata), .MEM_BYTE_EN(mem_be), .MEM_RDATA(mem_rdata),
        .MEM_ACK(mem_ack)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic uns, input logic [1:0] size,
                                input logic [31:0] a, input logic [31:0] d, input logic [31:0] rd,
                                input int delay, input logic [31:0] ld, input logic [3:0] be,
                                input logic [31:0] wd, input logic m, input logic e);
        vec_t v;
        v.st = st; v.uns = uns; v.size = size; v.addr = a; v.data = d; v.rdata = rd;
        v.delay = delay; v.load = ld; v.be = be; v.wdata = wd; v.mis = m; v.err = e;
        return v;
    endfunction

    // Reference model: derives expectations from sizes in bytes and lane arithmetic.
    function automatic vec_t model(input vec_t v);
        int          nbytes;
        int          lane;
        logic [63:0] raw;
        logic [63:0] mask;
        vec_t        r;
        r      = v;
        nbytes = (v.size == 2'd3) ? 0 : (1 << v.size);
        lane   = int'(v.addr % 4);
        r.mis  = (nbytes == 0) || ((v.addr % nbytes) != 0);
        r.err  = (v.delay + 1) > TO;
        r.be   = 4'd0;
        r.wdata = 32'd0;
        r.load = 32'd0;
        if (!r.mis) begin
            if (v.st) begin
                r.be = 4'(((1 << nbytes) - 1) << lane);
                if (nbytes == 1)      r.wdata = (v.data & 32'hFF) * 32'h0101_0101;
                else if (nbytes == 2) r.wdata = (v.data & 32'hFFFF) * 32'h0001_0001;
                else                  r.wdata = v.data;
            end
            raw  = 64'(v.rdata) >> (8 * lane);
            mask = (64'd1 << (8 * nbytes)) - 64'd1;
            raw  = raw & mask;
            if (!v.uns && nbytes < 4 && raw[8*nbytes-1]) raw = raw | ~mask;
            r.load = r.err ? 32'd0 : raw[31:0];
        end
        return r;
    endfunction

    // One memory operation from its IDLE cycle through DONE; inputs change on the falling edge.
    task automatic run_op(input vec_t v, input string tag);
        int  req_cnt;
        int  busy_cnt;
        bit  done;
        @(negedge clk);
        sel = 1'b1; rw = {v.st, v.uns, v.size}; addr = v.addr; sdata = v.data; mem_ack = 1'b0;
        #1;
        check({tag, " load_hold"}, load_data, model_load);
        check({tag, " idle_busy"}, 32'(busy), 32'(!v.mis));
        check({tag, " idle_mis"}, 32'(mis), 32'(v.mis));
        check({tag, " idle_req"}, 32'(mem_req), 32'd0);
        if (v.mis) begin
            @(negedge clk);
            sel = 1'b0;
            #1;
            if (!v.st) model_load = 32'd0;
            check({tag, " mis_req"}, 32'(mem_req), 32'd0);
            check({tag, " mis_load"}, load_data, model_load);
            $display("op %s st=%0b size=%0d addr=%08h misaligned load=%08h", tag, v.st, v.size, v.addr, load_data);
            return;
        end
        req_cnt = 0; busy_cnt = 1; done = 0;
        for (int k = 1; k <= TO && !done; k++) begin
            @(negedge clk);
            mem_ack   = (k == v.delay + 1);
            mem_rdata = mem_ack ? v.rdata : $urandom;
            #1;
            if (mem_req) req_cnt++;
            if (busy) busy_cnt++;
            if (k == 1) begin
                check({tag, " addr"}, mem_addr, v.addr & 32'hFFFF_FFFC);
                check({tag, " we"}, 32'(mem_we), 32'(v.st));
                check({tag, " be"}, 32'(mem_be), 32'(v.be));
                if (v.st) check({tag, " wdata"}, mem_wdata, v.wdata);
            end
            if (mem_ack) done = 1;
        end
        @(negedge clk);
        // Ack and data in DONE must be ignored.
        mem_ack = 1'b1; mem_rdata = $urandom;
        #1;
        if (!v.st) model_load = v.load;
        check({tag, " req_cycles"}, 32'(req_cnt), v.err ? 32'(TO) : 32'(v.delay + 1));
        check({tag, " busy_cycles"}, 32'(busy_cnt), v.err ? 32'(TO + 1) : 32'(v.delay + 2));
        check({tag, " done_busy"}, 32'(busy), 32'd0);
        check({tag, " bus_err"}, 32'(bus_err), 32'(v.err));
        check({tag, " done_bus"}, {mem_req, mem_we, mem_be}, 32'd0);
        check({tag, " load"}, load_data, model_load);
        $display("op %s st=%0b size=%0d addr=%08h delay=%0d err=%0b load=%08h", tag, v.st, v.size, v.addr, v.delay, bus_err, load_data);
    endtask

    initial begin
        vec_t tbl[11];
        vec_t v;
        reset = 1'b1; sel = 1'b0; rw = 4'd0; addr = 32'd0; sdata = 32'd0;
        mem_rdata = 32'd0; mem_ack = 1'b0; model_load = 32'd0;
        @(negedge clk); @(negedge clk);
        check("rst_outs", {busy, mis, bus_err, mem_req, mem_we, mem_be}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_load", load_data, 32'd0);
        reset = 1'b0;

        //           st   uns  size   addr          data          rdata         dly load          be       wdata         mis  err
        tbl[0]  = mk(1'b0, 1'b0, 2'd0, 32'h103, 32'h0,         32'h80FF_1234, 1, 32'hFFFF_FF80, 4'b0000, 32'h0,         1'b0, 1'b0);
        tbl[1]  = mk(1'b0, 1'b1, 2'd1, 32'h202, 32'h0,         32'h9ABC_0000, 0, 32'h0000_9ABC, 4'b0000, 32'h0,         1'b0, 1'b0);
        tbl[2]  = mk(1'b0, 1'b0, 2'd2, 32'h204, 32'h0,         32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 4'b0000, 32'h0,         1'b0, 1'b0);
        tbl[3]  = mk(1'b1, 1'b0, 2'd0, 32'h31,  32'h1234_56A5, 32'h0,         0, 32'h0,         4'b0010, 32'hA5A5_A5A5, 1'b0, 1'b0);
        tbl[4]  = mk(1'b1, 1'b0, 2'd1, 32'h32,  32'h0000_BEEF, 32'h0,         2, 32'h0,         4'b1100, 32'hBEEF_BEEF, 1'b0, 1'b0);
        tbl[5]  = mk(1'b0, 1'b0, 2'd2, 32'h102, 32'h0,         32'h0,         0, 32'h0,         4'b0000, 32'h0,         1'b1, 1'b0);
        tbl[6]  = mk(1'b0, 1'b1, 2'd0, 32'h41,  32'h0,         32'h0000_C300, 0, 32'h0000_00C3, 4'b0000, 32'h0,         1'b0, 1'b0);
        tbl[7]  = mk(1'b0, 1'b0, 2'd3, 32'h100, 32'h0,         32'h0,         0, 32'h0,         4'b0000, 32'h0,         1'b1, 1'b0);
        tbl[8]  = mk(1'b0, 1'b0, 2'd2, 32'h40,  32'h0,         32'h1111_1111, 9, 32'h0,         4'b0000, 32'h0,         1'b0, 1'b1);
        tbl[9]  = mk(1'b0, 1'b0, 2'd2, 32'h44,  32'h0,         32'hCAFE_F00D, 3, 32'hCAFE_F00D, 4'b0000, 32'h0,         1'b0, 1'b0);
        tbl[10] = mk(1'b0, 1'b0, 2'd1, 32'h46,  32'h0,         32'h8001_0000, 1, 32'hFFFF_8001, 4'b0000, 32'h0,         1'b0, 1'b0);
        for (int i = 0; i < 11; i++) run_op(tbl[i], $sformatf("tbl%0d", i));

        // Reset in the middle of an access drops the request at once.
        @(negedge clk);
        sel = 1'b1; rw = 4'b0010; addr = 32'h8; mem_ack = 1'b0;
        @(negedge clk);
        #1;
        check("rst_mid_req_before", 32'(mem_req), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_req", 32'(mem_req), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        @(negedge clk);
        sel = 1'b0;
        reset = 1'b0;
        model_load = 32'd0;
        #1;
        check("rst_mid_load", load_data, 32'd0);
        $display("op reset_mid_access req=%0b busy=%0b", mem_req, busy);
        run_op(mk(1'b0, 1'b0, 2'd2, 32'h8, 32'h0, 32'h1234_5678, 0, 32'h1234_5678, 4'b0000, 32'h0, 1'b0, 1'b0), "after_rst");

        // Randomized operations checked against the reference model.
        for (int i = 0; i < 60; i++) begin
            v.st    = 1'($urandom);
            v.uns   = 1'($urandom);
            v.size  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            v.addr  = $urandom;
            v.data  = $urandom;
            v.rdata = $urandom;
            v.delay = $urandom_range(0, TO + 1);
            v = model(v);
            run_op(v, $sformatf("rnd%0d", i));
        end

        @(negedge clk);
        sel = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
